// File: rtl/gpio_in_debounce_pkg.sv
// Shared GPIO definitions: pin-bus width, event word field offsets, CPU operand type.
// Constants only; no logic.
package gpio_in_debounce_pkg;

    localparam int GPIO_W           = 8;
    localparam int GPIO_EV_RISE_LSB = 0;
    localparam int GPIO_EV_FALL_LSB = GPIO_W;

    typedef logic [GPIO_W-1:0] gpio_bus_t;
    typedef logic [31:0]       RV32I_OPERAND_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-pin synchroniser plus stability counter; emits one-cycle rise/fall pulses on accept.
// Latency: SYNC_STAGES + DEBOUNCE_CYC edges from first sampling edge to stable change.
// No backpressure: free-running every cycle.
module gpio_debounce_bit
    import gpio_in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW      = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   accept;

    assign synced = sync[SYNC_STAGES-1];
    // Saturation of the counter is the accept point, so it can never wrap.
    assign accept = (synced != stable) && (cnt == CNT_MAX);
    assign rise   = accept &  synced;
    assign fall   = accept & ~synced;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (synced == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// Conditions raw pad inputs for the GPIO block; holds sticky W1C edge flags and the irq.
// Latency: port_clean SYNC_STAGES+DEBOUNCE_CYC edges; ev_rddata and irq one edge after flags.
// No backpressure: writes take effect next edge, reads are always valid.
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int WIDTH        = GPIO_W,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [31:0]      ev_wrdata,
    input  logic             ev_wren,
    output logic [WIDTH-1:0] port_clean,
    output logic [31:0]      ev_rddata,
    output logic             irq
);

    localparam int FALL_LSB = GPIO_EV_RISE_LSB + WIDTH;

    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    RV32I_OPERAND_t   rd_word;
    logic             unused_wrdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .pin    (pin_in[i]),
            .stable (port_clean[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i])
        );
    end

    assign rise_clr      = ev_wren ? ev_wrdata[GPIO_EV_RISE_LSB +: WIDTH] : '0;
    assign fall_clr      = ev_wren ? ev_wrdata[FALL_LSB +: WIDTH] : '0;
    assign unused_wrdata = ^ev_wrdata;

    always_comb begin
        rd_word                            = '0;
        rd_word[GPIO_EV_RISE_LSB +: WIDTH] = rise_ev;
        rd_word[FALL_LSB +: WIDTH]         = fall_ev;
    end

    // A new edge in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rise_ev   <= '0;
            fall_ev   <= '0;
            ev_rddata <= '0;
            irq       <= 1'b0;
        end else begin
            rise_ev   <= (rise_ev & ~rise_clr) | rise_pulse;
            fall_ev   <= (fall_ev & ~fall_clr) | fall_pulse;
            ev_rddata <= rd_word;
            irq       <= |((rise_ev | fall_ev) & irq_en);
        end
    end

endmodule
